mem_request_unit: RTL and testbench

Parametrised memory request unit for the multi-cycle successor to the single-cycle core. It arbitrates between the fetch port (PC-driven) and the data port (load/store from the ALU result) onto one shared memory bus. The memory side uses a variable-latency ack handshake. The unit returns one-cycle ready strobes with registered read data, and provides round-robin or data-priority arbitration plus a timeout/abort counter.

---
 rtl/mem_request_unit.sv | 148 ++++++++++++++
 tb/tb_mem_request_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_unit.sv
// Memory request unit: arbitrates fetch and data ports onto one shared memory bus
// with a variable-latency ack handshake, registered read data and an abort timeout.
module mem_request_unit #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 16,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, RESP} state_t;
  typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t              state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                resp_data_q, resp_data_d;

  logic data_req;
  logic grant_data;
  logic grant_any;
  logic in_access;
  logic abort;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_FETCH;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      resp_data_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Round-robin only matters on a conflict: give it to whichever port did not win last.
  always_comb begin
    data_req   = d_wen | d_ren;
    grant_data = data_req &&
                 (!i_req || (DATA_PRIORITY != 0) || (last_grant_q == GRANT_FETCH));
    grant_any  = data_req | i_req;
    in_access  = (state_q == FETCH) || (state_q == DREAD) || (state_q == DWRITE);
    abort      = TO_EN && in_access && !mem_ack && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_data)  state_d = d_wen ? DWRITE : DREAD;
        else if (i_req)  state_d = FETCH;
      end
      FETCH, DREAD, DWRITE: begin
        if (mem_ack || abort) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    resp_data_d  = resp_data_q;

    if (state_q == IDLE && grant_any) begin
      last_grant_d = grant_data ? GRANT_DATA : GRANT_FETCH;
      addr_d       = grant_data ? d_addr : i_addr;
      if (grant_data && d_wen) wdata_d = d_wdata;
      cnt_d        = '0;
      err_d        = 1'b0;
      resp_data_d  = grant_data;
    end else if (in_access) begin
      // An ack arriving in the final timeout cycle takes precedence over the abort.
      if (mem_ack) begin
        if (state_q == FETCH) i_rdata_d = mem_rdata;
        if (state_q == DREAD) d_rdata_d = mem_rdata;
      end else if (abort) begin
        if (state_q == FETCH) i_rdata_d = '0;
        if (state_q == DREAD) d_rdata_d = '0;
        err_d = 1'b1;
      end else if (TO_EN) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mem_ren   = (state_q == FETCH) || (state_q == DREAD);
    mem_wen   = (state_q == DWRITE);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_ready   = (state_q == RESP) && !resp_data_q;
    d_ready   = (state_q == RESP) && resp_data_q;
    bus_err   = (state_q == RESP) && err_q;
    busy      = (state_q != IDLE);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed testbench for mem_request_unit: a data-priority instance with a driven
// memory, plus a round-robin instance behind a zero-wait memory for arbitration.
module tb_mem_request_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          d_ren = 1'b0;
  logic          d_wen = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          ack_drv = 1'b0;
  logic          auto_ack = 1'b0;
  logic [DW-1:0] rr_rdata = 32'h5555_AAAA;

  logic          i_ready, d_ready, mem_ren, mem_wen, bus_err, busy, mem_ack;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          rr_i_ready, rr_d_ready, rr_mem_ren, rr_mem_wen, rr_bus_err, rr_busy, rr_mem_ack;
  logic [DW-1:0] rr_i_rdata, rr_d_rdata, rr_mem_wdata;
  logic [AW-1:0] rr_mem_addr;

  logic [5:0] st;

  int checks = 0;
  int failures = 0;

  assign st         = {mem_ren, mem_wen, i_ready, d_ready, bus_err, busy};
  assign mem_ack    = auto_ack ? (mem_ren | mem_wen) : ack_drv;
  assign rr_mem_ack = rr_mem_ren | rr_mem_wen;

  always #5 clk = ~clk;

  mem_request_unit #(
    .ADDR_W(AW), .DATA_W(DW), .DATA_PRIORITY(1), .TIMEOUT(4), .CNT_W(8)
  ) dut (
    .clk(clk), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .busy(busy)
  );

  mem_request_unit #(
    .ADDR_W(AW), .DATA_W(DW), .DATA_PRIORITY(0), .TIMEOUT(4), .CNT_W(8)
  ) dut_rr (
    .clk(clk), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_ready(rr_i_ready), .i_rdata(rr_i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(rr_d_ready), .d_rdata(rr_d_rdata),
    .mem_ren(rr_mem_ren), .mem_wen(rr_mem_wen), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
    .mem_rdata(rr_rdata), .mem_ack(rr_mem_ack), .bus_err(rr_bus_err), .busy(rr_busy)
  );

  // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    tick(); tick();
    checks++;
    if (st !== 6'b000000) begin
      failures++; $display("[TB] FAIL reset_status got=%b exp=%b", st, 6'b000000);
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      failures++; $display("[TB] FAIL reset_bus got=%h exp=0", {mem_addr, mem_wdata});
    end
    nRST = 1'b1;
    tick();
    checks++;
    if (st !== 6'b000000) begin
      failures++; $display("[TB] FAIL idle_after_reset got=%b exp=%b", st, 6'b000000);
    end
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    tick();
    checks++;
    if (st !== 6'b100001 || mem_addr !== 32'h10) begin
      failures++; $display("[TB] FAIL fetch_strobe got=%b/%h exp=100001/00000010", st, mem_addr);
    end
    i_req = 1'b0;
    tick();
    checks++;
    if (st !== 6'b100001) begin
      failures++; $display("[TB] FAIL fetch_wait got=%b exp=100001", st);
    end
    ack_drv = 1'b1; mem_rdata = 32'h00A0_0093;
    tick();
    ack_drv = 1'b0;
    checks++;
    if (st !== 6'b001001 || i_rdata !== 32'h00A0_0093) begin
      failures++; $display("[TB] FAIL fetch_resp got=%b/%h exp=001001/00a00093", st, i_rdata);
    end
    tick();
    checks++;
    if (st !== 6'b000000) begin
      failures++; $display("[TB] FAIL fetch_idle got=%b exp=000000", st);
    end
  endtask

  task automatic test_store();
    d_wen = 1'b1; d_addr = 32'h24; d_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (st !== 6'b010001 || mem_addr !== 32'h24 || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL store_strobe got=%b/%h/%h exp=010001/00000024/deadbeef", st, mem_addr, mem_wdata);
    end
    ack_drv = 1'b1; d_wen = 1'b0;
    tick();
    ack_drv = 1'b0;
    checks++;
    if (st !== 6'b000101 || d_rdata !== 32'h0) begin
      failures++; $display("[TB] FAIL store_resp got=%b/%h exp=000101/00000000", st, d_rdata);
    end
    tick();
    checks++;
    if (st !== 6'b000000) begin
      failures++; $display("[TB] FAIL store_idle got=%b exp=000000", st);
    end
  endtask

  task automatic test_ack_last_cycle();
    d_ren = 1'b1; d_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      tick();
      d_ren = 1'b0;
      checks++;
      if (st !== 6'b100001) begin
        failures++; $display("[TB] FAIL lastack_wait%0d got=%b exp=100001", k, st);
      end
    end
    ack_drv = 1'b1; mem_rdata = 32'h0000_1234;
    tick();
    ack_drv = 1'b0;
    checks++;
    if (st !== 6'b000101 || d_rdata !== 32'h1234) begin
      failures++; $display("[TB] FAIL lastack_resp got=%b/%h exp=000101/00001234", st, d_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    d_ren = 1'b1; d_addr = 32'h44;
    for (int k = 0; k < 4; k++) begin
      tick();
      d_ren = 1'b0;
      checks++;
      if (st !== 6'b100001) begin
        failures++; $display("[TB] FAIL timeout_wait%0d got=%b exp=100001", k, st);
      end
    end
    tick();
    checks++;
    if (st !== 6'b000111 || d_rdata !== 32'h0) begin
      failures++; $display("[TB] FAIL timeout_resp got=%b/%h exp=000111/00000000", st, d_rdata);
    end
    tick();
    checks++;
    if (st !== 6'b000000) begin
      failures++; $display("[TB] FAIL timeout_idle got=%b exp=000000", st);
    end
  endtask

  task automatic test_reset_mid_access();
    i_req = 1'b1; i_addr = 32'h80;
    tick();
    checks++;
    if (st !== 6'b100001) begin
      failures++; $display("[TB] FAIL rstmid_strobe got=%b exp=100001", st);
    end
    nRST = 1'b0; i_req = 1'b0;
    tick();
    checks++;
    if (st !== 6'b000000 || i_rdata !== 32'h0) begin
      failures++; $display("[TB] FAIL rstmid_drop got=%b/%h exp=000000/00000000", st, i_rdata);
    end
    ack_drv = 1'b1; nRST = 1'b1;
    tick();
    ack_drv = 1'b0;
    checks++;
    if (st !== 6'b000000) begin
      failures++; $display("[TB] FAIL rstmid_late_ack got=%b exp=000000", st);
    end
    i_req = 1'b1; i_addr = 32'h84;
    tick();
    checks++;
    if (st !== 6'b100001 || mem_addr !== 32'h84) begin
      failures++; $display("[TB] FAIL rstmid_refetch got=%b/%h exp=100001/00000084", st, mem_addr);
    end
    ack_drv = 1'b1; mem_rdata = 32'hCAFE_F00D; i_req = 1'b0;
    tick();
    ack_drv = 1'b0;
    checks++;
    if (st !== 6'b001001 || i_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("[TB] FAIL rstmid_refetch_resp got=%b/%h exp=001001/cafef00d", st, i_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] g, rg;
    int n, rn, di, dd, ri, rd, errs;
    int rr_bad_addr, main_bad_addr;
    g = '0; rg = '0;
    n = 0; rn = 0; di = 0; dd = 0; ri = 0; rd = 0; errs = 0;
    rr_bad_addr = 0; main_bad_addr = 0;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    i_req = 1'b1; d_ren = 1'b1; d_wen = 1'b1;
    d_addr = 32'h100; i_addr = 32'h200; d_wdata = 32'h0BAD_F00D;
    auto_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (mem_ren || mem_wen) begin
        if (n < 4) g[n] = mem_wen;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'h0BAD_F00D || !busy) main_bad_addr++;
        n++;
      end
      if (rr_mem_ren || rr_mem_wen) begin
        if (rn < 4) rg[rn] = rr_mem_wen;
        if (rr_mem_addr !== (((rn % 2) == 0) ? 32'h100 : 32'h200) || !rr_busy) rr_bad_addr++;
        if (rr_mem_wen && rr_mem_wdata !== 32'h0BAD_F00D) rr_bad_addr++;
        rn++;
      end
      if (i_ready) di++;
      if (d_ready) dd++;
      if (rr_i_ready) ri++;
      if (rr_d_ready) rd++;
      if (bus_err || rr_bus_err) errs++;
    end
    i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    tick(); tick();
    auto_ack = 1'b0;
    checks++;
    if (n !== 4 || g !== 4'b1111) begin
      failures++; $display("[TB] FAIL prio_grants got=%0d/%b exp=4/1111", n, g);
    end
    checks++;
    if (rn !== 4 || rg !== 4'b0101) begin
      failures++; $display("[TB] FAIL rr_grants got=%0d/%b exp=4/0101", rn, rg);
    end
    checks++;
    if (di !== 0 || dd !== 4) begin
      failures++; $display("[TB] FAIL prio_ready got=i%0d/d%0d exp=i0/d4", di, dd);
    end
    checks++;
    if (ri !== 2 || rd !== 2) begin
      failures++; $display("[TB] FAIL rr_ready got=i%0d/d%0d exp=i2/d2", ri, rd);
    end
    checks++;
    if (errs !== 0 || main_bad_addr !== 0 || rr_bad_addr !== 0) begin
      failures++;
      $display("[TB] FAIL b2b_bus got=err%0d/main%0d/rr%0d exp=0/0/0", errs, main_bad_addr, rr_bad_addr);
    end
    checks++;
    if (rr_i_rdata !== 32'h5555_AAAA || rr_d_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL b2b_rdata got=%h/%h/%h exp=5555aaaa/00000000/00000000", rr_i_rdata, rr_d_rdata, d_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_ack_last_cycle();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
